// File: rtl/fifo_memory_pkg.sv
// rtl/fifo_memory_pkg.sv - shared defaults and count-width helper for the fifo_memory block
package fifo_memory_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // count has to represent DEPTH itself, hence one bit above the pointer width
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_memory_if.sv
// rtl/fifo_memory_if.sv - request/status bundle between a host and fifo_memory
interface fifo_memory_if
  import fifo_memory_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CW = count_width(DEPTH);

  logic             chipselect;
  logic             write;
  logic             read;
  logic [WIDTH-1:0] I;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output chipselect, write, read, I,
    input  full, empty, count, overflow, underflow
  );

  modport slave (
    input  chipselect, write, read, I,
    output full, empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_memory_ptr.sv
// rtl/fifo_memory_ptr.sv - wrapping FIFO pointer with increment enable
module fifo_ptr #(
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // DEPTH is a power of two, so natural overflow gives the gapless wrap
  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/tristate_buf.sv
// rtl/tristate_buf.sv - parametrised tristate output buffer
module tristate_buf #(
  parameter int WIDTH = 8
) (
  input  logic             oe,
  input  logic [WIDTH-1:0] d,
  output wire  [WIDTH-1:0] y
);

  assign y = oe ? d : {WIDTH{1'bz}};

endmodule

// File: rtl/fifo_memory.sv
// rtl/fifo_memory.sv - chip-selected synchronous FIFO with registered, tristated read port
module fifo_memory
  import fifo_memory_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  fifo_memory_if.slave     bus,
  output wire  [WIDTH-1:0] O
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             full, empty;
  logic             push_acc, pop_acc;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // a full FIFO may still take a push when the same edge frees a slot
  assign pop_acc  = bus.chipselect & bus.read & ~empty;
  assign push_acc = bus.chipselect & bus.write & (~full | pop_acc);

  always_comb begin
    mem_d       = mem_q;
    count_d     = count_q;
    dout_d      = dout_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (push_acc) mem_d[wr_ptr] = bus.I;
    if (pop_acc)  dout_d = mem_q[rd_ptr];

    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (bus.chipselect & bus.write & ~push_acc) overflow_d  = 1'b1;
    if (bus.chipselect & bus.read  & empty)     underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ptr #(.PW(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (reset),
    .inc   (push_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.PW(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (reset),
    .inc   (pop_acc),
    .ptr   (rd_ptr)
  );

  tristate_buf #(.WIDTH(WIDTH)) u_obuf (
    .oe (bus.chipselect),
    .d  (dout_q),
    .y  (O)
  );

  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: doc/fifo_memory.md
FIFO_MEMORY -- requirements
Module: fifo_memory

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, minimum 1.
REQ-002 Parameter DEPTH, default 8: number of stored words; power of two, minimum 2.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port chipselect, input, 1: enables both operations and drives O when high.
REQ-006 Port write, input, 1: push request.
REQ-007 Port read, input, 1: pop request.
REQ-008 Port I, input, WIDTH: push data.
REQ-009 Port O, output, WIDTH: registered pop data when chipselect is high; high-impedance when chipselect is low.
REQ-010 Port full, output, 1: high when count equals DEPTH.
REQ-011 Port empty, output, 1: high when count equals 0.
REQ-012 Port count, output, $clog2(DEPTH)+1: number of stored words.
REQ-013 Port overflow, output, 1: sticky error flag for a rejected push.
REQ-014 Port underflow, output, 1: sticky error flag for a rejected pop.

Function
REQ-015 Push accepted = chipselect & write & (!full | pop accepted); on acceptance, mem[wr_ptr] <= I and wr_ptr increments.
REQ-016 Pop accepted = chipselect & read & !empty; on acceptance, the output register <= mem[rd_ptr] and rd_ptr increments; read latency is 1 cycle.
REQ-017 With no accepted pop, the output register holds its value.
REQ-018 Pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 with no gap.
REQ-019 count: +1 on push only; -1 on pop only; unchanged on both or neither.
REQ-020 When full with simultaneous push and pop, both are accepted and count stays DEPTH.
REQ-021 When empty with simultaneous push and pop, only the push is accepted; there is no write-through bypass, and underflow is set.
REQ-022 A push request while full without an accepted pop is dropped; storage and pointers are unchanged; overflow <= 1.
REQ-023 A pop request while empty is dropped; the output register is unchanged; underflow <= 1.
REQ-024 overflow and underflow stay set until reset.
REQ-025 With chipselect low, write and read are ignored and no state changes, including error flags.
REQ-026 full, empty and count are combinational decodes of registered state and are valid in the same cycle as that state.

Reset
REQ-027 reset low asynchronously clears wr_ptr, rd_ptr, count, the output register, overflow, underflow and all storage words to 0.
REQ-028 After reset: empty=1, full=0, count=0; O=0 if chipselect is high, else Z.
REQ-029 reset asserted mid-operation aborts any in-flight push or pop; that edge has no effect.
REQ-030 Normal operation resumes at the first rising clk edge after reset deasserts.

Structure
REQ-031 Shared package holds the WIDTH/DEPTH defaults and the count-width function ($clog2(DEPTH)+1).
REQ-032 Output tristating reuses the team's existing parametrised tristate buffer, widened to WIDTH.
REQ-033 One sub-module, fifo_ptr, implements a wrapping pointer: increment enable, asynchronous active-low reset, $clog2(DEPTH) bits; it is instantiated twice.

Verification
REQ-034 Reset, then chipselect=1, push 0x11,0x22,0x33, pop 3 times -> O=0x11,0x22,0x33, each one cycle after its pop; then empty=1, count=0.
REQ-035 Push 8 words 0xA0..0xA7 (DEPTH=8) -> full=1, count=8; 9th push 0xFF -> overflow=1, count=8; pop 8 times -> 0xA0..0xA7, with no 0xFF.
REQ-036 Full, simultaneous push 0x55 and pop -> O=0xA0, count=8; after draining, 0x55 is the last word out; wrap-around of both pointers confirmed.
REQ-037 Empty, simultaneous push 0x77 and pop -> underflow=1, count=1, O unchanged; next pop -> O=0x77.
REQ-038 Push 0x3C, set chipselect=0, then pulse write and read -> O=Z, count=1, no flags set; set chipselect=1 -> O shows the previous register value.
REQ-039 Assert reset mid-stream with count=5 and no clock edge -> immediately count=0, empty=1, flags=0, O=0.
